stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream `reg_fifo` write port among `NUM_REQ` valid/ready requesters. It sits directly in front of the FIFO's `in_*` port: it picks one requester per cycle, registers the winning beat together with its source ID, and presents it to the FIFO. Fairness is rotating-priority. Multi-beat packets can optionally be kept contiguous with a compile-time lock feature.

---
 rtl/stream_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Rotating-priority arbiter feeding a single registered valid/ready output slot.
// Define STREAM_RR_ARBITER_PKT_LOCK_EN to hold the grant on one requester until its in_last beat.
module stream_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LB_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clear,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [LB_NUM_REQ-1:0]         out_id,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  logic                  load;
  logic                  any_elig;
  logic                  xfer;
  logic [NUM_REQ-1:0]    elig;
  logic [LB_NUM_REQ-1:0] winner;
  logic [LB_NUM_REQ-1:0] winner_inc;
  logic [LB_NUM_REQ-1:0] ptr_q, ptr_d;
  logic                  lock_active;
  logic [LB_NUM_REQ-1:0] lock_owner;
  logic                  adv_ptr;

  assign load = !out_valid || out_ready;
  assign elig = lock_active ? (in_valid & (NUM_REQ'(1) << lock_owner)) : in_valid;

  // Circular scan starting at ptr; explicit wrap keeps non-power-of-two counts in range.
  always_comb begin
    int unsigned idx;
    any_elig = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        winner   = LB_NUM_REQ'(idx);
      end
    end
  end

  assign winner_inc = (winner == LB_NUM_REQ'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign xfer       = load && !clear && any_elig;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready = NUM_REQ'(1) << winner;
  end

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  typedef enum logic [0:0] {StIdle, StLocked} lock_state_e;

  lock_state_e           state_q, state_d;
  logic [LB_NUM_REQ-1:0] owner_q, owner_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (clear) begin
      state_d = StIdle;
      owner_d = '0;
    end else if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (!in_last[winner]) begin
            state_d = StLocked;
            owner_d = winner;
          end
        end
        StLocked: begin
          if (in_last[winner]) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pointer only moves once a packet has ended, in either state.
  always_comb begin
    lock_active = (state_q == StLocked);
    lock_owner  = owner_q;
    adv_ptr     = in_last[winner];
  end
`else
  assign lock_active = 1'b0;
  assign lock_owner  = '0;
  assign adv_ptr     = 1'b1;
`endif

  always_comb begin
    ptr_d = ptr_q;
    if (clear)              ptr_d = '0;
    else if (xfer && adv_ptr) ptr_d = winner_inc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
      out_id    <= winner;
      out_last  <= in_last[winner];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected beats, negedge monitors pop and compare.
// Covers a 4-requester instance and a 3-requester instance for pointer wrap.
module tb_stream_rr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_last, out_valid, out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_id3;
  logic        out_last3, out_valid3, out_ready3;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt0;
  logic [10:0] q4[$];
  logic [10:0] q3[$];

  always #5 clk = ~clk;

  stream_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) u_dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
    .out_data(out_data3), .out_id(out_id3), .out_last(out_last3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic push4(input logic [1:0] id, input logic [7:0] data, input logic last);
    q4.push_back({last, id, data});
  endtask

  task automatic push3(input logic [1:0] id, input logic [7:0] data, input logic last);
    q3.push_back({last, id, data});
  endtask

  // A slot beat is consumed when valid & ready at the coming edge and no clear discards it.
  always @(negedge clk) begin
    if (rstn && !clear && out_valid && out_ready) begin
      if (q4.size() == 0) begin
        n_checks++;
        $display("FAIL beat4_unexpected: got %0h expected none", {out_last, out_id, out_data});
      end else begin
        check("beat4", {21'b0, out_last, out_id, out_data}, {21'b0, q4.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && !clear && out_valid3 && out_ready3) begin
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL beat3_unexpected: got %0h expected none", {out_last3, out_id3, out_data3});
      end else begin
        check("beat3", {21'b0, out_last3, out_id3, out_data3}, {21'b0, q3.pop_front()});
      end
    end
  end

  initial begin
    rstn       = 1'b0;
    clear      = 1'b0;
    in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid   = '0;
    in_last    = '0;
    out_ready  = 1'b1;
    in_data3   = {8'hB2, 8'hB1, 8'hB0};
    in_valid3  = '0;
    in_last3   = '0;
    out_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset / idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle4", {in_ready, out_valid, out_last, out_id, out_data}, 32'h0);
      check("reset_idle3", {in_ready3, out_valid3, out_last3, out_id3, out_data3}, 32'h0);
    end

    // Full contention: 0,1,2,3 repeating, one beat per cycle
    tick();
    in_last  = 4'hF;
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) push4(2'(i % 4), 8'hA0 + 8'(i % 4), 1'b1);
    repeat (8) tick();
    check("throughput", q4.size(), 1);
    in_valid = '0;
    repeat (2) tick();

    // Backpressure: first beat id 1 held, then 3, 1
    pulse_clear();
    in_valid = 4'b1010;
    push4(2'd1, 8'hA1, 1'b1);
    push4(2'd3, 8'hA3, 1'b1);
    push4(2'd1, 8'hA1, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {in_ready, out_valid, out_id, out_data}, {4'b0, 1'b1, 2'd1, 8'hA1});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) tick();
    in_valid = '0;
    repeat (2) tick();

    // Clear mid-stream discards the held beat and resets ptr / lock
    pulse_clear();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    tick();
    clear    = 1'b1;
    in_valid = 4'b0011;
    @(negedge clk);
    check("slot_before_clear", {out_valid, out_id}, {1'b1, 2'd1});
    check("clear_masks_ready", in_ready, 4'b0000);
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 4'b0101;
    in_last  = 4'hF;
    @(negedge clk);
    check("clear_flush", out_valid, 1'b0);
    check("post_clear_grant", in_ready, 4'b0001);
    push4(2'd0, 8'hA0, 1'b1);
    tick();
    in_valid = '0;
    repeat (2) tick();

    // Packet lock: requester 0 sends 3 beats (last 0,0,1) against a busy requester 1
    pulse_clear();
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    push4(2'd0, 8'hA0, 1'b0);
    push4(2'd0, 8'hA0, 1'b0);
    push4(2'd0, 8'hA0, 1'b1);
    push4(2'd1, 8'hA1, 1'b1);
    push4(2'd1, 8'hA1, 1'b1);
`else
    push4(2'd0, 8'hA0, 1'b0);
    push4(2'd1, 8'hA1, 1'b1);
    push4(2'd0, 8'hA0, 1'b0);
    push4(2'd1, 8'hA1, 1'b1);
    push4(2'd0, 8'hA0, 1'b1);
`endif
    cnt0     = 0;
    in_last  = 4'b1110;
    in_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) cnt0++;
      @(posedge clk);
      #1;
      in_valid[0] = (cnt0 < 3);
      in_last[0]  = (cnt0 == 2);
    end
    in_valid = '0;
    repeat (2) tick();

    // Non-power-of-two wrap on the 3-requester instance
    pulse_clear();
    in_last3  = 3'b111;
    in_valid3 = 3'b100;
    push3(2'd2, 8'hB2, 1'b1);
    push3(2'd2, 8'hB2, 1'b1);
    push3(2'd0, 8'hB0, 1'b1);
    push3(2'd1, 8'hB1, 1'b1);
    push3(2'd2, 8'hB2, 1'b1);
    repeat (2) tick();
    in_valid3 = 3'b111;
    repeat (3) tick();
    in_valid3 = '0;
    repeat (2) tick();

    for (int i = 0; i < 20 && (q4.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    check("q4_drained", q4.size(), 0);
    check("q3_drained", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
